hazard_scoreboard: RTL and testbench
====================================

Name: hazard_scoreboard

Overview:
- Parametrised hazard/forwarding unit for the in-order pipelined RISC-V core.
- Replaces the fixed "stall on any in-flight rd match" scheme with a per-stage writer scoreboard.
- The scoreboard drives operand forwarding selects, load-use stalls, flush of the issuing instruction, and saturating performance counters.
- Sits beside the ID stage. It is told what issues from ID each cycle and what each downstream stage currently holds.

Parameters:
- XLEN, 32, data width.
- RA_W, 5, register address width.
- DEPTH, 3, number of in-flight stages after ID (slot 0 = EX ... slot DEPTH-1 = WB).
- FWD_EN, 1, 1 = forward when data is ready; 0 = stall-only mode (legacy behaviour).
- CNT_W, 32, performance counter width.

Ports:
- clk  in  1  clock
- reset  in  1  synchronous active-high reset
- issue_valid  in  1  ID holds a real instruction this cycle
- issue_rf_wen  in  1  that instruction writes rd
- issue_is_load  in  1  its result comes from data memory
- issue_rd  in  RA_W  its destination register
- rs1_addr, rs2_addr  in  RA_W  ID source registers
- rs1_use, rs2_use  in  1  source is actually read
- flush  in  1  jump taken in EX; the ID instruction is squashed
- res_data  in  DEPTH*XLEN  result currently held by stage k (slice k)
- res_ready  in  DEPTH  slice k of res_data is valid (ALU result, or load data once past MEM)
- stall  out  1  hold PC and IF/ID; insert bubble into EX
- fwd1_sel, fwd2_sel  out  clog2(DEPTH+1)  0 = register file, k+1 = slot k
- fwd1_data, fwd2_data  out  XLEN  selected forwarded value (0 when sel = 0)
- stall_cnt, fwd_cnt  out  CNT_W  saturating event counters

Behaviour:
- State: DEPTH slots, each holding {valid, rd, is_load}. Two counters.
- Every cycle, slots shift (slot k -> k+1); slot DEPTH-1 retires.
- Slot 0 loads {issue_valid & issue_rf_wen & (issue_rd != 0) & !stall & !flush, issue_rd, issue_is_load}.
- stall or flush therefore inserts a bubble (valid = 0). Older slots always advance; the pipeline below ID never stalls.
- Lookup per source s:
  - Condition: s_use = 1 and addr != 0.
  - Scan slot 0 first; the youngest matching valid slot wins.
  - No match: sel = 0, no hazard.
  - Match in slot k with FWD_EN = 1 and res_ready[k] = 1: sel = k+1, data = res_data slice k.
  - Match with FWD_EN = 0 or res_ready[k] = 0: hazard.
  - Hazard always applies even if an older slot is ready, because the youngest writer is authoritative.
- stall = hazard on rs1 | hazard on rs2, forced 0 when flush = 1 (the squashed instruction must not stall).
- While stall = 1, fwd selects are still driven but are don't-care to consumers.
- The WB slot (DEPTH-1) is forwarded because the register file is read before write in the same cycle.
- Outputs are combinational from slot state and current inputs. No added latency; stall is asserted in the same cycle as the hazard.
- Counters:
  - stall_cnt increments on each cycle with stall = 1.
  - fwd_cnt increments on each cycle with !stall & !flush & (fwd1_sel != 0 | fwd2_sel != 0), by 1 per cycle, not per operand.
  - Both saturate at all-ones with no wrap.
- Reset (synchronous): all slots invalid and counters 0. Outputs during and after reset: stall = 0, sel = 0, data = 0, cnt = 0.
- Reset asserted mid-stall clears the slots; stall drops the cycle after the reset edge.
- x0 is never tracked and never hazarded.
- issue_rd == rs of the same instruction is not self-hazarded; only slots are checked.
- A load followed immediately by a use (DEPTH = 3, res_ready[0] = 0 for loads) gives exactly one stall cycle. The load then sits in slot 1 with ready = 1, so the dependent instruction forwards.
- flush and stall on the same cycle: flush wins, a bubble is inserted, stall = 0.

Test Plan:
- Back-to-back ALU dependency: issue addi x5 (ready), next cycle rs1 = x5 with res_ready[0] = 1 and res_data slice 0 = 0x1234 -> stall = 0, fwd1_sel = 1, fwd1_data = 0x1234, fwd_cnt = 1.
- Load-use: issue lw x6 (is_load), next cycle rs2 = x6 with res_ready[0] = 0 -> stall = 1 for exactly 1 cycle; following cycle fwd2_sel = 2 with res_data slice 1 value; stall_cnt = 1.
- Youngest wins: x7 written in slot 2 (ready, 0xAAAA) and slot 0 (ready, 0xBBBB); rs1 = x7 -> fwd1_sel = 1, data = 0xBBBB. With slot 0 not ready -> stall = 1.
- FWD_EN = 0 build: addi x5 then a use of x5 -> stall for 3 cycles; fourth cycle sel = 0, stall_cnt = 3.
- x0 and flush: issue rd = x0 then rs1 = x0 -> no stall, sel = 0. A hazard with flush = 1 -> stall = 0 and the next slot 0 is invalid.
- Reset mid-hazard: lw x6 then a use of x6 stalling; assert reset one cycle -> slots cleared, stall = 0, counters 0. Saturation: preload, force counter to all-ones minus 1 and stall 2 cycles -> holds all-ones.

Source files
------------

// File: rtl/hazard_scoreboard.sv
// Per-stage writer scoreboard for the in-order pipeline: tracks which downstream
// stage will write each register and derives forwarding selects, load-use stalls and event counters.
module hazard_scoreboard #(
   parameter int XLEN   = 32,
   parameter int RA_W   = 5,
   parameter int DEPTH  = 3,
   parameter int FWD_EN = 1,
   parameter int CNT_W  = 32
) (
   input  logic                         clk,
   input  logic                         reset,
   input  logic                         issue_valid,
   input  logic                         issue_rf_wen,
   input  logic                         issue_is_load,
   input  logic [RA_W-1:0]              issue_rd,
   input  logic [RA_W-1:0]              rs1_addr,
   input  logic [RA_W-1:0]              rs2_addr,
   input  logic                         rs1_use,
   input  logic                         rs2_use,
   input  logic                         flush,
   input  logic [DEPTH*XLEN-1:0]        res_data,
   input  logic [DEPTH-1:0]             res_ready,
   output logic                         stall,
   output logic [$clog2(DEPTH+1)-1:0]   fwd1_sel,
   output logic [$clog2(DEPTH+1)-1:0]   fwd2_sel,
   output logic [XLEN-1:0]              fwd1_data,
   output logic [XLEN-1:0]              fwd2_data,
   output logic [CNT_W-1:0]             stall_cnt,
   output logic [CNT_W-1:0]             fwd_cnt
);

   localparam int SEL_W = $clog2(DEPTH+1);

   logic [DEPTH-1:0] slot_valid;
   logic [DEPTH-1:0] slot_load;
   logic [RA_W-1:0]  slot_rd [DEPTH];

   logic [DEPTH-1:0] fwd_ok;
   logic [RA_W-1:0]  src_addr [2];
   logic             src_use  [2];
   logic [SEL_W-1:0] src_sel  [2];
   logic [XLEN-1:0]  src_data [2];
   logic             src_haz  [2];

   logic             stall_int;
   logic             fwd_evt;
   logic [CNT_W-1:0] stall_q;
   logic [CNT_W-1:0] fwd_q;

   assign src_addr[0] = rs1_addr;
   assign src_addr[1] = rs2_addr;
   assign src_use[0]  = rs1_use;
   assign src_use[1]  = rs2_use;

   // A load still in EX has no data yet, whatever res_ready claims for that slot.
   assign fwd_ok = (FWD_EN != 0) ? (res_ready & ~(slot_load & DEPTH'(1))) : '0;

   // Scan oldest to youngest so the youngest matching writer overrides older ones.
   always_comb begin
      for (int s = 0; s < 2; s++) begin
         src_sel[s]  = '0;
         src_data[s] = '0;
         src_haz[s]  = 1'b0;
         if (src_use[s] && (src_addr[s] != '0)) begin
            for (int k = DEPTH-1; k >= 0; k--) begin
               if (slot_valid[k] && (slot_rd[k] == src_addr[s])) begin
                  if (fwd_ok[k]) begin
                     src_sel[s]  = SEL_W'(k+1);
                     src_data[s] = res_data[k*XLEN +: XLEN];
                     src_haz[s]  = 1'b0;
                  end else begin
                     src_sel[s]  = '0;
                     src_data[s] = '0;
                     src_haz[s]  = 1'b1;
                  end
               end
            end
         end
      end
   end

   assign stall_int = (src_haz[0] | src_haz[1]) & ~flush & ~reset;
   assign stall     = stall_int;
   assign fwd1_sel  = reset ? '0 : src_sel[0];
   assign fwd2_sel  = reset ? '0 : src_sel[1];
   assign fwd1_data = reset ? '0 : src_data[0];
   assign fwd2_data = reset ? '0 : src_data[1];
   assign fwd_evt   = ~stall_int & ~flush & ((fwd1_sel != '0) | (fwd2_sel != '0));
   assign stall_cnt = reset ? '0 : stall_q;
   assign fwd_cnt   = reset ? '0 : fwd_q;

   // Slots always advance; a stalled or squashed issue enters slot 0 as a bubble.
   always_ff @(posedge clk) begin
      if (reset) begin
         slot_valid <= '0;
         slot_load  <= '0;
         for (int k = 0; k < DEPTH; k++) begin
            slot_rd[k] <= '0;
         end
      end else begin
         slot_valid[0] <= issue_valid & issue_rf_wen & (issue_rd != '0) & ~stall_int & ~flush;
         slot_load[0]  <= issue_is_load;
         slot_rd[0]    <= issue_rd;
         for (int k = 1; k < DEPTH; k++) begin
            slot_valid[k] <= slot_valid[k-1];
            slot_load[k]  <= slot_load[k-1];
            slot_rd[k]    <= slot_rd[k-1];
         end
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         stall_q <= '0;
         fwd_q   <= '0;
      end else begin
         if (stall_int && (stall_q != '1)) begin
            stall_q <= stall_q + 1'b1;
         end
         if (fwd_evt && (fwd_q != '1)) begin
            fwd_q <= fwd_q + 1'b1;
         end
      end
   end

endmodule

// File: tb/tb_hazard_scoreboard.sv
// Directed bench for hazard_scoreboard: a vector table for single-cycle lookups plus
// short hand sequences for load-use, stall-only mode, mid-hazard reset and counter saturation.
module tb_hazard_scoreboard;

   localparam logic [31:0] D0 = 32'h0000_1234;
   localparam logic [31:0] D1 = 32'h5555_0001;
   localparam logic [31:0] D2 = 32'h6666_0002;

   typedef struct {
      logic        iv, iw, il;
      logic [4:0]  ird;
      logic [4:0]  a1;
      logic        u1;
      logic [4:0]  a2;
      logic        u2;
      logic        fl;
      logic [2:0]  rdy;
      logic [31:0] d0, d1, d2;
      logic        es;
      logic [1:0]  s1;
      logic [31:0] e1;
      logic [1:0]  s2;
      logic [31:0] e2;
   } vec_t;

   logic        clk = 1'b0;
   logic        reset;
   logic        issue_valid, issue_rf_wen, issue_is_load;
   logic [4:0]  issue_rd, rs1_addr, rs2_addr;
   logic        rs1_use, rs2_use, flush;
   logic [95:0] res_data;
   logic [2:0]  res_ready;

   logic        stall, nf_stall, sat_stall;
   logic [1:0]  fwd1_sel, fwd2_sel, nf_sel1, nf_sel2, sat_sel1, sat_sel2;
   logic [31:0] fwd1_data, fwd2_data, nf_data1, nf_data2, sat_data1, sat_data2;
   logic [31:0] stall_cnt, fwd_cnt, nf_stall_cnt, nf_fwd_cnt;
   logic [1:0]  sat_stall_cnt, sat_fwd_cnt;

   int n_tests = 0;
   int n_fail  = 0;
   vec_t tbl [20];

   always #5 clk = ~clk;

   hazard_scoreboard dut (
      .clk(clk), .reset(reset), .issue_valid(issue_valid), .issue_rf_wen(issue_rf_wen),
      .issue_is_load(issue_is_load), .issue_rd(issue_rd), .rs1_addr(rs1_addr), .rs2_addr(rs2_addr),
      .rs1_use(rs1_use), .rs2_use(rs2_use), .flush(flush), .res_data(res_data), .res_ready(res_ready),
      .stall(stall), .fwd1_sel(fwd1_sel), .fwd2_sel(fwd2_sel), .fwd1_data(fwd1_data),
      .fwd2_data(fwd2_data), .stall_cnt(stall_cnt), .fwd_cnt(fwd_cnt)
   );

   hazard_scoreboard #(.FWD_EN(0)) dut_nf (
      .clk(clk), .reset(reset), .issue_valid(issue_valid), .issue_rf_wen(issue_rf_wen),
      .issue_is_load(issue_is_load), .issue_rd(issue_rd), .rs1_addr(rs1_addr), .rs2_addr(rs2_addr),
      .rs1_use(rs1_use), .rs2_use(rs2_use), .flush(flush), .res_data(res_data), .res_ready(res_ready),
      .stall(nf_stall), .fwd1_sel(nf_sel1), .fwd2_sel(nf_sel2), .fwd1_data(nf_data1),
      .fwd2_data(nf_data2), .stall_cnt(nf_stall_cnt), .fwd_cnt(nf_fwd_cnt)
   );

   hazard_scoreboard #(.CNT_W(2)) dut_sat (
      .clk(clk), .reset(reset), .issue_valid(issue_valid), .issue_rf_wen(issue_rf_wen),
      .issue_is_load(issue_is_load), .issue_rd(issue_rd), .rs1_addr(rs1_addr), .rs2_addr(rs2_addr),
      .rs1_use(rs1_use), .rs2_use(rs2_use), .flush(flush), .res_data(res_data), .res_ready(res_ready),
      .stall(sat_stall), .fwd1_sel(sat_sel1), .fwd2_sel(sat_sel2), .fwd1_data(sat_data1),
      .fwd2_data(sat_data2), .stall_cnt(sat_stall_cnt), .fwd_cnt(sat_fwd_cnt)
   );

   function automatic vec_t mk(logic iv, logic iw, logic il, logic [4:0] ird,
                               logic [4:0] a1, logic u1, logic [4:0] a2, logic u2, logic fl,
                               logic [2:0] rdy, logic [31:0] d0, logic [31:0] d1, logic [31:0] d2,
                               logic es, logic [1:0] s1, logic [31:0] e1,
                               logic [1:0] s2, logic [31:0] e2);
      vec_t v;
      v.iv = iv; v.iw = iw; v.il = il; v.ird = ird;
      v.a1 = a1; v.u1 = u1; v.a2 = a2; v.u2 = u2; v.fl = fl;
      v.rdy = rdy; v.d0 = d0; v.d1 = d1; v.d2 = d2;
      v.es = es; v.s1 = s1; v.e1 = e1; v.s2 = s2; v.e2 = e2;
      return v;
   endfunction

   function automatic vec_t idle();
      return mk(0,0,0,0, 0,0, 0,0, 0, 3'b000, D0,D1,D2, 0, 0,0, 0,0);
   endfunction

   task automatic check(string name, logic [31:0] act, logic [31:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("[TB] FAIL %s: got %0h, expected %0h", name, act, exp);
      end
   endtask

   task automatic applyStimulus(vec_t v);
      issue_valid   = v.iv;
      issue_rf_wen  = v.iw;
      issue_is_load = v.il;
      issue_rd      = v.ird;
      rs1_addr      = v.a1;
      rs1_use       = v.u1;
      rs2_addr      = v.a2;
      rs2_use       = v.u2;
      flush         = v.fl;
      res_ready     = v.rdy;
      res_data      = {v.d2, v.d1, v.d0};
      #4;
   endtask

   task automatic checkOutput(vec_t v, int idx);
      check($sformatf("row%0d stall", idx), {31'b0, stall}, {31'b0, v.es});
      if (!v.es && !v.fl) begin
         check($sformatf("row%0d fwd1_sel", idx), {30'b0, fwd1_sel}, {30'b0, v.s1});
         check($sformatf("row%0d fwd2_sel", idx), {30'b0, fwd2_sel}, {30'b0, v.s2});
         check($sformatf("row%0d fwd1_data", idx), fwd1_data, v.e1);
         check($sformatf("row%0d fwd2_data", idx), fwd2_data, v.e2);
      end
   endtask

   task automatic nextCycle();
      @(posedge clk);
      #1;
   endtask

   task automatic doReset();
      reset = 1'b1;
      applyStimulus(idle());
      nextCycle();
      reset = 1'b0;
   endtask

   initial begin
      // Each row is one cycle; slot occupancy (EX,MEM,WB) after the edge is noted per row.
      tbl[0]  = mk(1,1,0,5,  0,0,  0,0,  0, 3'b111, D0,D1,D2,           0, 0,0,         0,0);          // x5,-,-
      tbl[1]  = mk(1,1,0,8,  5,1,  0,0,  0, 3'b111, D0,D1,D2,           0, 1,D0,        0,0);          // x8,x5,-
      tbl[2]  = mk(1,1,1,6,  5,1,  8,1,  0, 3'b111, D0,D1,D2,           0, 2,D1,        1,D0);         // ld6,x8,x5
      tbl[3]  = mk(1,1,0,9,  0,0,  6,1,  0, 3'b110, D0,D1,D2,           1, 0,0,         0,0);          // -,ld6,x8
      tbl[4]  = mk(1,1,0,9,  0,0,  6,1,  0, 3'b111, D0,32'h7777,D2,     0, 0,0,         2,32'h7777);   // x9,-,ld6
      tbl[5]  = mk(1,1,0,7,  0,0,  0,0,  0, 3'b111, D0,D1,D2,           0, 0,0,         0,0);          // x7,x9,-
      tbl[6]  = idle();                                                                                // -,x7,x9
      tbl[7]  = mk(1,1,0,7,  0,0,  0,0,  0, 3'b111, D0,D1,D2,           0, 0,0,         0,0);          // x7,-,x7
      tbl[8]  = mk(0,0,0,0,  7,1,  0,0,  0, 3'b111, 32'hBBBB,D1,32'hAAAA, 0, 1,32'hBBBB, 0,0);        // -,x7,-
      tbl[9]  = mk(1,1,0,7,  0,0,  0,0,  0, 3'b111, D0,D1,D2,           0, 0,0,         0,0);          // x7,-,x7
      tbl[10] = mk(0,0,0,0,  7,1,  0,0,  0, 3'b100, 32'hBBBB,D1,32'hAAAA, 1, 0,0,       0,0);          // -,x7,-
      tbl[11] = mk(1,1,0,0,  0,0,  0,0,  0, 3'b111, D0,D1,D2,           0, 0,0,         0,0);          // -,-,x7
      tbl[12] = mk(0,0,0,0,  0,1,  7,1,  0, 3'b111, D0,D1,32'hCAFE,     0, 0,0,         3,32'hCAFE);   // -,-,-
      tbl[13] = mk(1,1,0,10, 0,0,  0,0,  0, 3'b111, D0,D1,D2,           0, 0,0,         0,0);          // x10,-,-
      tbl[14] = mk(1,1,0,11, 10,1, 0,0,  1, 3'b000, D0,D1,D2,           0, 0,0,         0,0);          // -,x10,-
      tbl[15] = mk(0,0,0,0,  11,1, 10,1, 0, 3'b010, D0,32'h1010,D2,     0, 0,0,         2,32'h1010);   // -,-,x10
      tbl[16] = mk(0,0,0,0,  10,1, 0,0,  0, 3'b000, D0,D1,D2,           1, 0,0,         0,0);          // -,-,-
      tbl[17] = mk(0,0,0,0,  10,1, 0,0,  0, 3'b000, D0,D1,D2,           0, 0,0,         0,0);          // -,-,-
      tbl[18] = mk(1,1,0,12, 12,1, 0,0,  0, 3'b000, D0,D1,D2,           0, 0,0,         0,0);          // x12,-,-
      tbl[19] = mk(0,0,0,0,  12,0, 12,0, 0, 3'b000, D0,D1,D2,           0, 0,0,         0,0);          // -,x12,-

      doReset();
      applyStimulus(idle());
      check("reset stall", {31'b0, stall}, 32'd0);
      check("reset fwd1_sel", {30'b0, fwd1_sel}, 32'd0);
      check("reset stall_cnt", stall_cnt, 32'd0);
      check("reset fwd_cnt", fwd_cnt, 32'd0);
      nextCycle();

      for (int i = 0; i < 20; i++) begin
         applyStimulus(tbl[i]);
         checkOutput(tbl[i], i);
         nextCycle();
      end
      applyStimulus(idle());
      check("table stall_cnt", stall_cnt, 32'd3);
      check("table fwd_cnt", fwd_cnt, 32'd6);
      nextCycle();

      // Load-use: one stall, then the load forwards from MEM.
      doReset();
      applyStimulus(mk(1,1,1,6, 0,0, 0,0, 0, 3'b000, D0,D1,D2, 0,0,0,0,0));
      check("lu issue stall", {31'b0, stall}, 32'd0);
      nextCycle();
      applyStimulus(mk(1,1,0,9, 0,0, 6,1, 0, 3'b000, D0,D1,D2, 0,0,0,0,0));
      check("lu stall", {31'b0, stall}, 32'd1);
      nextCycle();
      applyStimulus(mk(1,1,0,9, 0,0, 6,1, 0, 3'b010, D0,32'hD00D,D2, 0,0,0,0,0));
      check("lu release stall", {31'b0, stall}, 32'd0);
      check("lu fwd2_sel", {30'b0, fwd2_sel}, 32'd2);
      check("lu fwd2_data", fwd2_data, 32'hD00D);
      nextCycle();
      applyStimulus(idle());
      check("lu stall_cnt", stall_cnt, 32'd1);
      check("lu fwd_cnt", fwd_cnt, 32'd1);
      nextCycle();

      // Stall-only build waits for the writer to retire.
      doReset();
      applyStimulus(mk(1,1,0,5, 0,0, 0,0, 0, 3'b111, D0,D1,D2, 0,0,0,0,0));
      nextCycle();
      for (int c = 0; c < 4; c++) begin
         applyStimulus(mk(1,1,0,9, 5,1, 0,0, 0, 3'b111, D0,D1,D2, 0,0,0,0,0));
         check($sformatf("nf stall c%0d", c), {31'b0, nf_stall}, (c < 3) ? 32'd1 : 32'd0);
         if (c == 3) check("nf fwd1_sel", {30'b0, nf_sel1}, 32'd0);
         nextCycle();
      end
      applyStimulus(idle());
      check("nf stall_cnt", nf_stall_cnt, 32'd3);
      nextCycle();

      // Reset during a load-use stall.
      doReset();
      applyStimulus(mk(1,1,1,6, 0,0, 0,0, 0, 3'b000, D0,D1,D2, 0,0,0,0,0));
      nextCycle();
      applyStimulus(mk(1,1,0,9, 0,0, 6,1, 0, 3'b000, D0,D1,D2, 0,0,0,0,0));
      check("mr pre stall", {31'b0, stall}, 32'd1);
      nextCycle();
      reset = 1'b1;
      applyStimulus(mk(1,1,0,9, 0,0, 6,1, 0, 3'b000, D0,D1,D2, 0,0,0,0,0));
      check("mr during stall", {31'b0, stall}, 32'd0);
      nextCycle();
      reset = 1'b0;
      applyStimulus(mk(1,1,0,9, 0,0, 6,1, 0, 3'b000, D0,D1,D2, 0,0,0,0,0));
      check("mr after stall", {31'b0, stall}, 32'd0);
      check("mr stall_cnt", stall_cnt, 32'd0);
      check("mr fwd_cnt", fwd_cnt, 32'd0);
      nextCycle();

      // Two-bit counter must stick at 3 once saturated.
      doReset();
      applyStimulus(mk(1,1,1,6, 0,0, 0,0, 0, 3'b000, D0,D1,D2, 0,0,0,0,0));
      nextCycle();
      for (int c = 0; c < 3; c++) begin
         applyStimulus(mk(1,1,0,9, 0,0, 6,1, 0, 3'b000, D0,D1,D2, 0,0,0,0,0));
         if (c == 2) check("sat cnt at 2", {30'b0, sat_stall_cnt}, 32'd2);
         nextCycle();
      end
      applyStimulus(mk(1,1,1,6, 0,0, 6,1, 0, 3'b000, D0,D1,D2, 0,0,0,0,0));
      check("sat reissue stall", {31'b0, sat_stall}, 32'd0);
      nextCycle();
      applyStimulus(mk(1,1,0,9, 0,0, 6,1, 0, 3'b000, D0,D1,D2, 0,0,0,0,0));
      nextCycle();
      applyStimulus(idle());
      check("sat cnt held", {30'b0, sat_stall_cnt}, 32'd3);
      check("wide stall_cnt", stall_cnt, 32'd4);
      nextCycle();

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
